// File: rtl/biquad_cascade.sv
// rtl/biquad_cascade.sv - cascade of transposed direct-form-II biquads, one section per clock
module biquad_cascade #(
  parameter int  DATA_W   = 32,
  parameter int  COEF_W   = 18,
  parameter int  FRAC     = 14,
  parameter int  SECTIONS = 2,
  localparam int AW       = $clog2(SECTIONS) + 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                coef_we,
  input  logic [AW-1:0]       coef_addr,
  input  logic [COEF_W-1:0]   coef_data,
  input  logic [SECTIONS-1:0] bypass,
  input  logic                clear_state,
  output logic                coef_err
);

  localparam int ACC_W = DATA_W + COEF_W + 2;
  localparam int SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << FRAC);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t state_q, state_d;
  logic [SW-1:0]            sec_q;
  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] out_q;
  logic                     coef_err_q;

  logic signed [COEF_W-1:0] b0_q [SECTIONS];
  logic signed [COEF_W-1:0] b1_q [SECTIONS];
  logic signed [COEF_W-1:0] b2_q [SECTIONS];
  logic signed [COEF_W-1:0] a1_q [SECTIONS];
  logic signed [COEF_W-1:0] a2_q [SECTIONS];
  logic signed [ACC_W-1:0]  z1_q [SECTIONS];
  logic signed [ACC_W-1:0]  z2_q [SECTIONS];

  logic signed [ACC_W-1:0]  x_ext, y_ext, acc_y, y_shr, z1_d, z2_d;
  logic [ACC_W-DATA_W:0]    y_hi;
  logic signed [DATA_W-1:0] y_sat, y_sec;
  logic                     last_sec, accept;

  function automatic logic signed [ACC_W-1:0] sext_c(input logic signed [COEF_W-1:0] c);
    return {{(ACC_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_d(input logic signed [DATA_W-1:0] d);
    return {{(ACC_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

  assign in_ready  = (state_q == IDLE) && !rst && !clear_state;
  assign accept    = in_valid && in_ready;
  assign last_sec  = (sec_q == SW'(SECTIONS - 1));
  assign out_valid = (state_q == OUT);
  assign out_data  = out_q;
  assign coef_err  = coef_err_q;

  // Arithmetic for the section selected by sec_q: output, saturation and new delay state
  always_comb begin
    x_ext = sext_d(x_q);
    acc_y = sext_c(b0_q[sec_q]) * x_ext + z1_q[sec_q];
    y_shr = acc_y >>> FRAC;
    y_hi  = y_shr[ACC_W-1:DATA_W-1];
    y_sat = y_shr[DATA_W-1:0];
    if (!((&y_hi) || (~|y_hi))) begin
      y_sat = y_shr[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    y_ext = sext_d(y_sat);
    z1_d  = sext_c(b1_q[sec_q]) * x_ext - sext_c(a1_q[sec_q]) * y_ext + z2_q[sec_q];
    z2_d  = sext_c(b2_q[sec_q]) * x_ext - sext_c(a2_q[sec_q]) * y_ext;
    y_sec = bypass[sec_q] ? x_q : y_sat;
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, walk sections in CALC, hold result in OUT until taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_sec) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: coefficient/delay storage, per-section update and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q      <= '0;
      x_q        <= '0;
      out_q      <= '0;
      coef_err_q <= 1'b0;
      for (int s = 0; s < SECTIONS; s++) begin
        b0_q[s] <= UNITY;
        b1_q[s] <= '0;
        b2_q[s] <= '0;
        a1_q[s] <= '0;
        a2_q[s] <= '0;
        z1_q[s] <= '0;
        z2_q[s] <= '0;
      end
    end else begin
      coef_err_q <= coef_we && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            x_q   <= in_data;
            sec_q <= '0;
          end
          for (int s = 0; s < SECTIONS; s++) begin
            if (clear_state) begin
              z1_q[s] <= '0;
              z2_q[s] <= '0;
            end
            if (coef_we && ((coef_addr >> 3) == AW'(s))) begin
              case (coef_addr[2:0])
                3'd0:    b0_q[s] <= coef_data;
                3'd1:    b1_q[s] <= coef_data;
                3'd2:    b2_q[s] <= coef_data;
                3'd3:    a1_q[s] <= coef_data;
                3'd4:    a2_q[s] <= coef_data;
                default: ;
              endcase
            end
          end
        end
        CALC: begin
          x_q <= y_sec;
          if (!bypass[sec_q]) begin
            z1_q[sec_q] <= z1_d;
            z2_q[sec_q] <= z2_d;
          end
          if (last_sec) out_q <= y_sec;
          else          sec_q <= sec_q + SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// tb/tb_biquad_cascade.sv - self-checking bench for biquad_cascade
module tb_biquad_cascade;

  localparam int DATA_W   = 32;
  localparam int COEF_W   = 18;
  localparam int SECTIONS = 2;
  localparam int AW       = $clog2(SECTIONS) + 3;

  typedef struct {
    int din;
    int dout;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [DATA_W-1:0]   in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                coef_we = 1'b0;
  logic [AW-1:0]       coef_addr = '0;
  logic [COEF_W-1:0]   coef_data = '0;
  logic [SECTIONS-1:0] bypass = '0;
  logic                clear_state = 1'b0;
  logic                coef_err;

  int   n_cmp = 0;
  int   n_err = 0;
  int   err_cnt = 0;
  int   exp_q[$];
  vec_t vq[$];

  biquad_cascade dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .bypass(bypass), .clear_state(clear_state), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; clear_state = 1'b0;
    bypass = '0; out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", longint'($signed(out_data)), 0);
    check("rst_coef_err", coef_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
  endtask

  task automatic write_coef(input int sec, input int idx, input int val);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = AW'(sec * 8 + idx); coef_data = COEF_W'(val);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic send(input int v, input int e, input bit drain);
    int n = 0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_data = v; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 32'h5a5a_5a5a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check("latency", n, SECTIONS + 1);
    if (drain) wait_drain();
  endtask

  task automatic run_vq();
    foreach (vq[i]) send(vq[i].din, vq[i].dout, 1'b1);
    vq.delete();
  endtask

  initial begin
    int ov;
    fork
      forever begin
        @(negedge clk);
        if (!rst && coef_err) err_cnt++;
        if (!rst && out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", longint'($signed(out_data)), -1);
          else check("out_data", longint'($signed(out_data)), exp_q.pop_front());
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
      end
    join_none

    // Unity passthrough after reset
    do_reset();
    vq.push_back('{1000, 1000});
    vq.push_back('{-5, -5});
    vq.push_back('{0, 0});
    vq.push_back('{123456, 123456});
    vq.push_back('{32'sh7fff_ffff, 32'sh7fff_ffff});
    vq.push_back('{32'sh8000_0000, 32'sh8000_0000});
    run_vq();

    // Three-tap FIR of halves in section 0
    write_coef(0, 0, 8192);
    write_coef(0, 1, 8192);
    write_coef(0, 2, 8192);
    vq.push_back('{100, 50});
    vq.push_back('{0, 50});
    vq.push_back('{0, 50});
    vq.push_back('{0, 0});
    run_vq();

    // First-order feedback, then clear_state
    do_reset();
    write_coef(0, 0, 16384);
    write_coef(0, 3, -8192);
    vq.push_back('{1024, 1024});
    vq.push_back('{0, 512});
    vq.push_back('{0, 256});
    vq.push_back('{0, 128});
    run_vq();
    @(posedge clk); #1;
    clear_state = 1'b1; in_valid = 1'b1; in_data = 999;
    @(negedge clk);
    check("clear_blocks_ready", in_ready, 0);
    @(posedge clk); #1;
    clear_state = 1'b0; in_valid = 1'b0;
    send(0, 0, 1'b1);

    // Saturation and floor rounding with gain ~2 per section
    do_reset();
    write_coef(0, 0, 32767);
    write_coef(1, 0, 32767);
    vq.push_back('{32'sh7fff_ffff, 32'sh7fff_ffff});
    vq.push_back('{32'sh8000_0000, 32'sh8000_0000});
    vq.push_back('{65536, 262128});
    vq.push_back('{-65536, -262129});
    run_vq();

    // Backpressure: result held, no new input accepted
    do_reset();
    out_ready = 1'b0;
    send(777, 777, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", longint'($signed(out_data)), 777);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // Coefficient write during CALC is dropped and flagged once
    err_cnt = 0;
    exp_q.push_back(42);
    @(posedge clk); #1;
    in_data = 42; in_valid = 1'b1;
    @(negedge clk);
    check("err_seq_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b1; coef_addr = '0; coef_data = '0;
    @(posedge clk); #1;
    coef_we = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("coef_err_pulses", err_cnt, 1);
    send(55, 55, 1'b1);

    // Unused index writes are silently ignored
    err_cnt = 0;
    write_coef(0, 5, 0);
    write_coef(1, 7, 0);
    repeat (2) @(negedge clk);
    check("idx5_no_err", err_cnt, 0);
    send(77, 77, 1'b1);

    // Bypass of section 0 around a zero-gain stage, section 1 gain 2
    do_reset();
    write_coef(0, 0, 0);
    write_coef(1, 0, 32768);
    bypass = 2'b01;
    send(300, 600, 1'b1);
    send(-7, -14, 1'b1);
    bypass = 2'b00;
    send(300, 0, 1'b1);

    // Reset in the middle of CALC aborts the sample and clears state
    do_reset();
    write_coef(0, 3, -8192);
    send(1024, 1024, 1'b1);
    @(posedge clk); #1;
    in_data = 2000; in_valid = 1'b1;
    @(negedge clk);
    check("abort_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ov = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    check("abort_no_out_valid", ov, 0);
    check("abort_ready_after", in_ready, 1);
    send(0, 0, 1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/biquad_cascade.md
BIQUAD_CASCADE -- requirements
Module: biquad_cascade

Interface
REQ-001 Parameters: DATA_W 32, sample width, two's complement.
REQ-002 Parameters: COEF_W 18, coefficient width, signed Q(COEF_W-FRAC).FRAC.
REQ-003 Parameters: FRAC 14, coefficient fractional bits (unity = 2^FRAC).
REQ-004 Parameters: SECTIONS 2, number of cascaded second-order sections, range 1..8.
REQ-005 Ports: clk, in, 1, the only clock; all logic on its rising edge.
REQ-006 Ports: rst, in, 1, synchronous, active-high reset.
REQ-007 Ports: in_data, in, DATA_W, input sample; in_valid, in, 1; in_ready, out, 1.
REQ-008 Ports: out_data, out, DATA_W, filtered sample; out_valid, out, 1; out_ready, in, 1.
REQ-009 Ports: coef_we, in, 1; coef_addr, in, clog2(SECTIONS)+3, section*8+index; coef_data, in, COEF_W.
REQ-010 Ports: bypass, in, SECTIONS, per-section bypass mask, sampled at the cycle the section is computed.
REQ-011 Ports: clear_state, in, 1, zeroes all delay state; coef_err, out, 1, one-cycle error pulse.

Function
REQ-012 Each section SHALL be transposed direct form II: y = b0*x + z1; z1' = b1*x - a1*y + z2; z2' = b2*x - a2*y; a0 is implicitly unity.
REQ-013 Coefficient index: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; indexes 5-7 and sections >= SECTIONS SHALL be ignored without error.
REQ-014 Products SHALL be full-precision signed; z1/z2 SHALL be held at ACC_W = DATA_W+COEF_W+2 bits, scaled by 2^FRAC, and wrap modulo 2^ACC_W.
REQ-015 Section output SHALL be (b0*x + z1) arithmetic-shifted right by FRAC (floor), then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-016 The saturated output of section k SHALL be the input of section k+1; the saturated output of the last section SHALL drive out_data.
REQ-017 A bypassed section SHALL pass x unchanged and SHALL NOT update its z1/z2.
REQ-018 FSM states: IDLE, CALC, OUT.
REQ-019 IDLE: in_ready=1; on in_valid&in_ready, latch in_data, set section index to 0, and go to CALC.
REQ-020 CALC: compute one section per cycle and update its state; after section SECTIONS-1, go to OUT.
REQ-021 OUT: out_valid=1 and out_data stable; on out_ready, go to IDLE; hold otherwise.
REQ-022 Latency: out_valid SHALL rise exactly SECTIONS+1 cycles after the accepting edge.
REQ-023 Throughput with out_ready held high: one sample per SECTIONS+2 cycles.
REQ-024 in_ready SHALL be 0 in CALC and OUT; in_data SHALL be ignored while in_ready=0.
REQ-025 A coef_we in IDLE SHALL write on that edge and take effect for the next accepted sample.
REQ-026 A coef_we outside IDLE SHALL be dropped and SHALL pulse coef_err for one cycle.
REQ-027 clear_state in IDLE SHALL zero every z1/z2 on that edge; in_ready SHALL be 0 that cycle, so no sample is accepted.
REQ-028 clear_state outside IDLE SHALL be ignored.

Reset
REQ-029 rst SHALL force: state IDLE; out_data 0; out_valid 0; coef_err 0; all z1/z2 0.
REQ-030 rst SHALL set every section to b0 = 2^FRAC and b1, b2, a1, a2 = 0, making the filter a unity passthrough.
REQ-031 in_ready SHALL be 0 during rst and 1 on the first cycle after rst is released.
REQ-032 rst asserted in CALC or OUT SHALL abort the sample; no out_valid SHALL be produced for it.
REQ-033 rst SHALL take priority over coef_we and clear_state.

Verification
REQ-034 Reset/passthrough: after rst, send 1000, then -5 -> out_data 1000 then -5, each out_valid 3 cycles after accept (SECTIONS=2).
REQ-035 FIR: section0 b0=b1=b2=8192, section1 default; impulse 100,0,0,0 -> outputs 50,50,50,0.
REQ-036 Feedback: section0 b0=16384, a1=-8192; impulse 1024 then zeros -> 1024,512,256,128; then clear_state and send 0 -> output 0.
REQ-037 Saturation: b0=32767 in both sections; input 2^31-1 -> out 2^31-1; input -2^31 -> out -2^31.
REQ-038 Backpressure/errors: out_ready low 5 cycles -> out_data held and in_ready 0; coef_we during CALC -> coef_err pulses once and coefficients are unchanged.
REQ-039 Bypass/reset: bypass=2'b01 with a gain-2 section1 -> in 300 gives out 600; rst mid-CALC -> no out_valid and state zeroed.
